// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Holds the controller state encoding and the coin denominations in cents.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;

endpackage

// File: rtl/change_dispenser.sv
// Change dispenser: loads an amount in cents on start and pays it back as one
// registered change pulse per cycle until the amount is exhausted.
// Build option: DIME_CHANGE_EN pays 10-cent pulses while 10 or more remains;
// without it only nickel pulses are produced and change_dime is tied to 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          load 'load' and begin paying (first pulse next cycle)
//   load           amount to pay back, multiple of 5, non-zero
//   change_nickel  registered pulse, 5 cents paid this cycle
//   change_dime    registered pulse, 10 cents paid this cycle
//   step           cents paid by the pulse currently shown (0 when idle)
//   done           the pulse currently shown is the last one
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CREDIT_W-1:0] load,
    output logic                change_nickel,
    output logic                change_dime,
    output logic [CREDIT_W-1:0] step,
    output logic                done
);

    localparam logic [CREDIT_W-1:0] NICKEL_AMT = CREDIT_W'(NICKEL_CENTS);
    localparam logic [CREDIT_W-1:0] DIME_AMT   = CREDIT_W'(DIME_CENTS);

    // Amount still owed, including the pulse currently on the outputs.
    logic [CREDIT_W-1:0] remain;
    logic [CREDIT_W-1:0] remain_next;
    logic                use_dime;

    always_comb begin
        step        = change_dime ? DIME_AMT : (change_nickel ? NICKEL_AMT : '0);
        done        = (change_nickel || change_dime) && (remain == step);
        remain_next = start ? load : remain - step;
    end

`ifdef DIME_CHANGE_EN
    assign use_dime = (remain_next >= DIME_AMT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_dime <= 1'b0;
        end else begin
            change_dime <= (remain_next != '0) && use_dime;
        end
    end
`else
    assign use_dime    = 1'b0;
    assign change_dime = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain        <= '0;
            change_nickel <= 1'b0;
        end else begin
            remain        <= remain_next;
            change_nickel <= (remain_next != '0) && !use_dime;
        end
    end

endmodule

// File: rtl/vend_credit_fsm.sv
// Vending credit controller: accumulates coin credit, pulses vend once the
// price is reached and returns excess (or the whole credit on cancel) through
// the change dispenser. All outputs are registered.
// Build option: DIME_CHANGE_EN enables 10-cent change pulses.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   coin_stb              coin lines are meaningful this cycle
//   nickel, dime, quarter coin lines (5, 10, 25 cents)
//   coin_valid            exactly one coin line is high
//   cancel                refund request (honoured only in COLLECT)
//   credit                current credit in cents
//   vend                  one-cycle dispense pulse
//   change_nickel         one pulse per 5 cents returned
//   change_dime           one pulse per 10 cents returned (DIME_CHANGE_EN only)
//   coin_reject           the strobed coin was returned
//   busy                  high in VEND and CHANGE
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = 65,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned MAX_CREDIT = 95
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_stb,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                coin_valid,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                change_nickel,
    output logic                change_dime,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state;
    logic [CREDIT_W-1:0] value;
    logic [CREDIT_W:0]   sum;    // one spare bit so the overflow test cannot wrap
    logic                accept;
    logic                start;
    logic [CREDIT_W-1:0] load;
    logic [CREDIT_W-1:0] chg_step;
    logic                chg_done;

    always_comb begin
        if (quarter) begin
            value = CREDIT_W'(QUARTER_CENTS);
        end else if (dime) begin
            value = CREDIT_W'(DIME_CENTS);
        end else if (nickel) begin
            value = CREDIT_W'(NICKEL_CENTS);
        end else begin
            value = '0;
        end
        sum    = {1'b0, credit} + {1'b0, value};
        // Cancel wins over a coin in the same cycle.
        accept = coin_stb && coin_valid && !cancel && (value != '0) &&
                 ((state == IDLE) || (state == COLLECT)) && (sum <= MAX_W);
        start  = ((state == VEND) && (credit > PRICE_C)) || ((state == COLLECT) && cancel);
        load   = (state == VEND) ? credit - PRICE_C : credit;
    end

    change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_change_dispenser (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .load          (load),
        .change_nickel (change_nickel),
        .change_dime   (change_dime),
        .step          (chg_step),
        .done          (chg_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            vend        <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vend        <= 1'b0;
            coin_reject <= coin_stb && !accept;
            unique case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        credit <= sum[CREDIT_W-1:0];
                        if (sum >= PRICE_W) begin
                            state <= VEND;
                            vend  <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end else if ((state == COLLECT) && cancel) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end
                end
                VEND: begin
                    credit <= credit - PRICE_C;
                    state  <= start ? CHANGE : IDLE;
                    busy   <= start;
                end
                CHANGE: begin
                    // Credit shows the amount still owed, including the current pulse.
                    credit <= credit - chg_step;
                    if (chg_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Self-checking bench for vend_credit_fsm. A transaction-level model schedules
// the expected per-cycle credit/busy values and the cycles on which each pulse
// output must fire; a separate monitor compares the DUT against those queues.
module tb_vend_credit_fsm;

    localparam int unsigned PRICE      = 65;
    localparam int unsigned CREDIT_W   = 8;
    localparam int unsigned MAX_CREDIT = 95;
`ifdef DIME_CHANGE_EN
    localparam bit DIME_EN = 1'b1;
`else
    localparam bit DIME_EN = 1'b0;
`endif

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b0;
    logic                coin_stb   = 1'b0;
    logic                nickel     = 1'b0;
    logic                dime       = 1'b0;
    logic                quarter    = 1'b0;
    logic                coin_valid = 1'b0;
    logic                cancel     = 1'b0;
    logic [CREDIT_W-1:0] credit;
    logic                vend;
    logic                change_nickel;
    logic                change_dime;
    logic                coin_reject;
    logic                busy;

    vend_credit_fsm #(
        .PRICE      (PRICE),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_stb      (coin_stb),
        .nickel        (nickel),
        .dime          (dime),
        .quarter       (quarter),
        .coin_valid    (coin_valid),
        .cancel        (cancel),
        .credit        (credit),
        .vend          (vend),
        .change_nickel (change_nickel),
        .change_dime   (change_dime),
        .coin_reject   (coin_reject),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int credit;
        bit busy;
    } cyc_exp_t;

    typedef struct {
        int cyc;
        bit dime;
    } pulse_exp_t;

    cyc_exp_t   q_cyc[$];
    pulse_exp_t q_vend[$];
    pulse_exp_t q_rej[$];
    pulse_exp_t q_chg[$];

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    bit mon_en   = 1'b0;

    // Model: credit held by the customer, plus a list of shown-credit values for
    // the cycles of an ongoing vend/refund (busy) period.
    int m_credit = 0;
    bit m_busy   = 1'b0;
    int m_sched[$];

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edges);
        end
    endtask

    task automatic sched_change(input int amount, input int first_cyc);
        int remain;
        int cy;
        bit dm;
        remain = amount;
        cy     = first_cyc;
        while (remain > 0) begin
            dm = DIME_EN && (remain >= 10);
            q_chg.push_back('{cy, dm});
            m_sched.push_back(remain);
            remain -= dm ? 10 : 5;
            cy++;
        end
    endtask

    // Expected consequences of the inputs sampled at the edge that starts cycle 'cyc'.
    task automatic model_edge(input bit stb, input bit n, input bit d, input bit q,
                              input bit v, input bit c, input int cyc);
        int value;
        bit was_busy;
        int shown;
        value    = q ? 25 : (d ? 10 : (n ? 5 : 0));
        was_busy = m_busy;
        if (c && !was_busy && (m_credit > 0)) begin
            sched_change(m_credit, cyc);
            m_credit = 0;
        end
        if (stb) begin
            if (!was_busy && v && !c && (value != 0) && (m_credit + value <= MAX_CREDIT)) begin
                m_credit += value;
                if (m_credit >= PRICE) begin
                    q_vend.push_back('{cyc, 1'b0});
                    m_sched.push_back(m_credit);
                    sched_change(m_credit - PRICE, cyc + 1);
                    m_credit = 0;
                end
            end else begin
                q_rej.push_back('{cyc, 1'b0});
            end
        end
        if (m_sched.size() > 0) begin
            shown  = m_sched.pop_front();
            m_busy = 1'b1;
        end else begin
            shown  = m_credit;
            m_busy = 1'b0;
        end
        q_cyc.push_back('{cyc, shown, m_busy});
    endtask

    task automatic step(input bit stb, input bit n, input bit d, input bit q,
                        input bit v, input bit c);
        coin_stb   = stb;
        nickel     = n;
        dime       = d;
        quarter    = q;
        coin_valid = v;
        cancel     = c;
        model_edge(stb, n, d, q, v, c, edges + 1);
        @(negedge clk);
    endtask

    task automatic coin(input int cents);
        step(1'b1, cents == 5, cents == 10, cents == 25, 1'b1, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic monitor_cycle();
        cyc_exp_t e;
        bit       exp_p;
        bit       exp_dime;
        if (q_cyc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL credit_queue: got credit %0d, expected an entry (cycle %0d)",
                     credit, edges);
        end else begin
            e = q_cyc.pop_front();
            check("credit", int'(credit), e.credit);
            check("busy", int'(busy), int'(e.busy));
        end

        exp_p = (q_vend.size() > 0) && (q_vend[0].cyc == edges);
        check("vend", int'(vend), int'(exp_p));
        if (exp_p) void'(q_vend.pop_front());

        exp_p = (q_rej.size() > 0) && (q_rej[0].cyc == edges);
        check("coin_reject", int'(coin_reject), int'(exp_p));
        if (exp_p) void'(q_rej.pop_front());

        exp_p    = (q_chg.size() > 0) && (q_chg[0].cyc == edges);
        exp_dime = exp_p && q_chg[0].dime;
        check("change_nickel", int'(change_nickel), int'(exp_p && !exp_dime));
        check("change_dime", int'(change_dime), int'(exp_dime));
        if (exp_p) void'(q_chg.pop_front());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) monitor_cycle();
        end
    end

    initial begin
        bit stb;
        bit n;
        bit d;
        bit q;
        bit v;
        bit c;
        int sel;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_credit", int'(credit), 0);
        check("rst_vend", int'(vend), 0);
        check("rst_change_nickel", int'(change_nickel), 0);
        check("rst_change_dime", int'(change_dime), 0);
        check("rst_coin_reject", int'(coin_reject), 0);
        check("rst_busy", int'(busy), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Exact price: 25, 50, 60, 65 -> vend, no change.
        coin(25); coin(25); coin(10); coin(5);
        idle(3);
        // 75 -> vend, 10 cents change.
        coin(25); coin(25); coin(25);
        idle(4);
        // 15 then cancel -> full refund.
        coin(10); coin(5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        // Invalid coin in IDLE and COLLECT, cancel in IDLE ignored.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        coin(5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // Coins during VEND and CHANGE, then coin plus cancel in COLLECT.
        coin(25); coin(25); coin(25);
        coin(5);
        coin(10);
        idle(4);
        coin(10);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(4);

        // Reset in the middle of returning 10 cents of change.
        coin(25); coin(25); coin(25);
        idle(1);
        mon_en = 1'b0;
        check("pre_reset_credit", int'(credit), 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_credit", int'(credit), 0);
        check("mid_rst_vend", int'(vend), 0);
        check("mid_rst_change_nickel", int'(change_nickel), 0);
        check("mid_rst_change_dime", int'(change_dime), 0);
        check("mid_rst_coin_reject", int'(coin_reject), 0);
        check("mid_rst_busy", int'(busy), 0);
        q_cyc.delete();
        q_vend.delete();
        q_rej.delete();
        q_chg.delete();
        m_sched.delete();
        m_credit = 0;
        m_busy   = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        coin(25);
        idle(5);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            stb = ($urandom_range(0, 99) < 35);
            c   = ($urandom_range(0, 99) < 7);
            v   = ($urandom_range(0, 9) != 0);
            if (v) begin
                sel = $urandom_range(0, 2);
                n   = (sel == 0);
                d   = (sel == 1);
                q   = (sel == 2);
            end else begin
                n = $urandom_range(0, 1) == 1;
                d = $urandom_range(0, 1) == 1;
                q = $urandom_range(0, 1) == 1;
            end
            step(stb, n, d, q, v, c);
        end
        idle(12);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
